// File: rtl/pc_fetch_gen_if.sv
// Instruction-fetch bus: memory request/ack handshake plus the redirect
// request coming from the control/execute stage.
interface pc_fetch_gen_if #(
    parameter int XLEN = 32
) ();
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic            redirect_valid;
    logic [1:0]      redirect_mode;
    logic [XLEN-1:0] redirect_base;
    logic [XLEN-1:0] redirect_offset;

    // Fetch-unit side: issues requests, consumes acks and redirects.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  redirect_valid,
        input  redirect_mode,
        input  redirect_base,
        input  redirect_offset
    );

    // Environment side: instruction memory and redirect source.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output redirect_valid,
        output redirect_mode,
        output redirect_base,
        output redirect_offset
    );
endinterface

// File: rtl/pc_fetch_gen.sv
// Program-counter generator. Holds one outstanding instruction-memory
// request at a time, follows sequential/redirected control flow and
// squashes wrong-path instructions that were in flight at a redirect.
module pc_fetch_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h100),
    parameter int              ILEN      = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    pc_fetch_gen_if.master  bus,
    output logic            fetch_valid_o,
    output logic [XLEN-1:0] pc_out_o,
    output logic            misalign_err_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] pend_addr_q, pend_addr_d;
    logic            pend_valid_q, pend_valid_d;
    logic            squash_q, squash_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fvalid_q, fvalid_d;
    logic            mis_q, mis_d;

    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] raw_target;
    logic            tgt_misaligned;
    logic [XLEN-1:0] target;

    // Redirect target: mode decode, then misaligned targets fall back to the trap vector.
    always_comb begin
        sum = bus.redirect_base + bus.redirect_offset;
        case (bus.redirect_mode)
            2'b00:   raw_target = sum;
            2'b01:   raw_target = {sum[XLEN-1:1], 1'b0};
            default: raw_target = TRAP_VEC;
        endcase
        tgt_misaligned = (raw_target % XLEN'(ILEN)) != '0;
        target         = tgt_misaligned ? TRAP_VEC : raw_target;
    end

    // Next-state logic: fetch sequencing, redirect capture and squash tracking.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        pend_addr_d  = pend_addr_q;
        pend_valid_d = pend_valid_q;
        squash_d     = squash_q;
        pc_d         = pc_q;
        fvalid_d     = 1'b0;
        mis_d        = bus.redirect_valid & tgt_misaligned;

        case (state_q)
            BOOT, HOLD: begin
                // No request outstanding, so a redirect simply retargets the next fetch.
                if (bus.redirect_valid) begin
                    addr_d = target;
                end
                state_d = stall_i ? HOLD : FETCH;
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    pc_d     = addr_q;
                    fvalid_d = ~(squash_q | bus.redirect_valid);
                    if (bus.redirect_valid) begin
                        addr_d = target;
                    end else if (pend_valid_q) begin
                        addr_d = pend_addr_q;
                    end else begin
                        addr_d = addr_q + XLEN'(ILEN);
                    end
                    pend_valid_d = 1'b0;
                    squash_d     = 1'b0;
                    state_d      = stall_i ? HOLD : FETCH;
                end else if (bus.redirect_valid) begin
                    // Request must stay stable until ack; remember where to go afterwards.
                    pend_addr_d  = target;
                    pend_valid_d = 1'b1;
                    squash_d     = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            addr_q       <= RESET_VEC;
            pend_addr_q  <= '0;
            pend_valid_q <= 1'b0;
            squash_q     <= 1'b0;
            pc_q         <= '0;
            fvalid_q     <= 1'b0;
            mis_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            pend_addr_q  <= pend_addr_d;
            pend_valid_q <= pend_valid_d;
            squash_q     <= squash_d;
            pc_q         <= pc_d;
            fvalid_q     <= fvalid_d;
            mis_q        <= mis_d;
        end
    end

    assign bus.imem_req   = (state_q == FETCH);
    assign bus.imem_addr  = addr_q;
    assign fetch_valid_o  = fvalid_q;
    assign pc_out_o       = pc_q;
    assign misalign_err_o = mis_q;

endmodule
